// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and sizing constants.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RKEYS  = NUM_ROUNDS + 1;
    localparam int KEY_W      = 128;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } ks_state_t;

endpackage

// File: rtl/key_expansion.sv
// Combinational AES-128 key expansion round.
// The working key goes in, the next round key comes out.
// The S-box is computed arithmetically (GF(2^8) inverse followed by the
// affine map) instead of being stored as a 256-entry table.
module key_expansion
    import aes_pkg::*;
#(
    parameter int KW = KEY_W
) (
    input  logic [3:0]    num_round,
    input  logic [KW-1:0] input_key,
    output logic [KW-1:0] output_key
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and it maps 0 to 0 as AES requires.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        logic [7:0] b;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // rcon[n] = x^n in GF(2^8); the loop is fixed-length so it synthesizes.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 15; i++) begin
            if (4'(i) < n) r = xtime(r);
        end
        return r;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [31:0] n0, n1, n2, n3;

    // One round: RotWord, SubWord and Rcon on the last word, then the xor chain.
    always_comb begin
        w0   = input_key[127:96];
        w1   = input_key[95:64];
        w2   = input_key[63:32];
        w3   = input_key[31:0];
        rot  = {w3[23:0], w3[31:24]};
        sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        temp = sub ^ {rcon(num_round), 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        output_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key schedule: expands one key per start into an 11-entry round-key
// table, streams each round key as it is produced, and serves registered
// table reads at any time.
module key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int KEY_W      = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_ready,
    output logic             rk_valid,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_data,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    localparam int         RKEYS    = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    ks_state_t state, state_nxt;
    logic            load;
    logic            step;
    logic            finish;
    logic [3:0]      cnt;
    logic [3:0]      cnt_inc;
    logic [KEY_W-1:0] work_key;
    logic [KEY_W-1:0] next_key;
    logic [RKEYS-1:0][KEY_W-1:0] key_table;

    assign cnt_inc = cnt + 4'd1;
    assign busy    = (state == EXPAND);

    key_expansion #(.KW(KEY_W)) u_round (
        .num_round (cnt),
        .input_key (work_key),
        .output_key(next_key)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the load / step / finish strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working key, round counter and table writes; each round lands at cnt+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            work_key  <= '0;
            key_table <= '0;
        end else if (load) begin
            cnt          <= 4'd0;
            work_key     <= key_in;
            key_table[0] <= key_in;
        end else if (step) begin
            cnt                <= cnt_inc;
            work_key           <= next_key;
            key_table[cnt_inc] <= next_key;
        end
    end

    // Stream port and completion flags, registered alongside the table write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_valid   <= 1'b0;
            rk_idx     <= 4'd0;
            rk_data    <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            rk_valid <= load | step;
            done     <= finish;
            if (load) begin
                rk_idx     <= 4'd0;
                rk_data    <= key_in;
                keys_ready <= 1'b0;
            end else if (step) begin
                rk_idx  <= cnt_inc;
                rk_data <= next_key;
            end
            if (finish) keys_ready <= 1'b1;
        end
    end

    // Registered table read; a write on the same edge is not visible until the next read.
    always_ff @(posedge clk) begin
        if (!rst_n)                 rd_key <= '0;
        else if (rd_idx <= LAST_IDX) rd_key <= key_table[rd_idx];
        else                        rd_key <= '0;
    end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 expansion vectors.
module tb_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, keys_ready, rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] K    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] K1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] K4   = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    localparam logic [127:0] K5   = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    localparam logic [127:0] K10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] Z1   = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] Z10  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
    localparam logic [127:0] ALT  = 128'hffeeddcc_bbaa9988_77665544_33221100;

    key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .keys_ready(keys_ready),
        .rk_valid  (rk_valid),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
        step();
        step();
        chk("rst_busy",     128'(busy),       128'd0);
        chk("rst_done",     128'(done),       128'd0);
        chk("rst_ready",    128'(keys_ready), 128'd0);
        chk("rst_valid",    128'(rk_valid),   128'd0);
        chk("rst_idx",      128'(rk_idx),     128'd0);
        chk("rst_data",     rk_data,          128'd0);
        chk("rst_rdkey",    rd_key,           128'd0);
        rst_n = 1'b1;
        step();

        // Full expansion of the FIPS-197 key, with an ignored start mid-run.
        start  = 1'b1;
        key_in = K;
        step();                         // edge T
        start  = 1'b0;
        chk("t0_valid", 128'(rk_valid), 128'd1);
        chk("t0_idx",   128'(rk_idx),   128'd0);
        chk("t0_data",  rk_data,        K);
        chk("t0_busy",  128'(busy),     128'd1);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) begin
                start  = 1'b1;          // 4th busy cycle: must be ignored
                key_in = ALT;
            end else begin
                start  = 1'b0;
            end
            chk($sformatf("s_idx%0d", i), 128'(rk_idx), 128'(i));
            chk($sformatf("s_vld%0d", i), 128'(rk_valid), 128'd1);
            if (i == 1)  chk("s_k1", rk_data, K1);
            if (i == 4)  chk("s_k4", rk_data, K4);
            if (i == 5)  chk("s_k5", rk_data, K5);
            if (i < 10) begin
                chk($sformatf("s_done%0d", i), 128'(done), 128'd0);
                chk($sformatf("s_busy%0d", i), 128'(busy), 128'd1);
            end
        end
        chk("s_k10",   rk_data,          K10);
        chk("s_done",  128'(done),       128'd1);
        chk("s_idle",  128'(busy),       128'd0);
        chk("s_ready", 128'(keys_ready), 128'd1);
        step();
        chk("s_done_end",  128'(done),     128'd0);
        chk("s_valid_end", 128'(rk_valid), 128'd0);
        chk("s_ready_hold", 128'(keys_ready), 128'd1);

        // Table reads.
        rd_idx = 4'd0;  step(); chk("rd0",  rd_key, K);
        rd_idx = 4'd1;  step(); chk("rd1",  rd_key, K1);
        rd_idx = 4'd5;  step(); chk("rd5",  rd_key, K5);
        rd_idx = 4'd10; step(); chk("rd10", rd_key, K10);
        rd_idx = 4'd11; step(); chk("rd11", rd_key, 128'd0);
        rd_idx = 4'd15; step(); chk("rd15", rd_key, 128'd0);

        // Reset in the middle of an expansion.
        start  = 1'b1;
        key_in = K;
        step();
        start  = 1'b0;
        for (int i = 1; i <= 5; i++) step();
        chk("ab_idx5", 128'(rk_idx), 128'd5);
        rst_n = 1'b0;
        start = 1'b1;                   // ignored while in reset
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("ab_busy",  128'(busy),       128'd0);
        chk("ab_ready", 128'(keys_ready), 128'd0);
        chk("ab_valid", 128'(rk_valid),   128'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("ab_done%0d", i), 128'(done), 128'd0);
            chk($sformatf("ab_bsy%0d", i),  128'(busy), 128'd0);
        end
        rd_idx = 4'd3; step(); chk("ab_rd3", rd_key, 128'd0);

        // Back-to-back: restart with the all-zero key in the done cycle.
        start  = 1'b1;
        key_in = K;
        step();
        start  = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        chk("bb_done", 128'(done), 128'd1);
        start  = 1'b1;
        key_in = '0;
        step();
        start  = 1'b0;
        chk("bb_idx0",   128'(rk_idx),     128'd0);
        chk("bb_data0",  rk_data,          128'd0);
        chk("bb_ready0", 128'(keys_ready), 128'd0);
        chk("bb_busy0",  128'(busy),       128'd1);
        step();
        chk("bb_idx1",   128'(rk_idx),     128'd1);
        chk("bb_z1",     rk_data,          Z1);
        chk("bb_ready1", 128'(keys_ready), 128'd0);
        for (int i = 2; i <= 10; i++) step();
        chk("bb_z10",    rk_data,          Z10);
        chk("bb_done2",  128'(done),       128'd1);
        chk("bb_ready2", 128'(keys_ready), 128'd1);
        rd_idx = 4'd1; step(); chk("bb_rd1", rd_key, Z1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the number of AES-128 expansion rounds (round keys = NUM_ROUNDS+1).
REQ-002 The block SHALL have parameter KEY_W, default 128, meaning the key and round-key width in bits.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, meaning a request to expand key_in; sampled only in IDLE.
REQ-006 The block SHALL have port key_in, input, KEY_W, meaning the cipher key; word 0 is in bits [127:96].
REQ-007 The block SHALL have port busy, output, 1, meaning expansion is in progress.
REQ-008 The block SHALL have port done, output, 1, meaning a one-cycle pulse when all round keys are stored.
REQ-009 The block SHALL have port keys_ready, output, 1, meaning the key table holds a complete, valid schedule.
REQ-010 The block SHALL have port rk_valid, output, 1, meaning rk_data/rk_idx carry a newly produced round key.
REQ-011 The block SHALL have port rk_idx, output, 4, meaning the round-key index 0..10 of rk_data.
REQ-012 The block SHALL have port rk_data, output, KEY_W, meaning the streamed round key.
REQ-013 The block SHALL have port rd_idx, input, 4, meaning the key-table read address.
REQ-014 The block SHALL have port rd_key, output, KEY_W, meaning the registered key-table read data.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and EXPAND; there is no other state.
REQ-016 In IDLE with start=1 at edge T, the block SHALL store key_in as table entry 0, load the working key with key_in, set the round counter to 0, and enter EXPAND.
REQ-017 Each EXPAND cycle SHALL apply one expansion round to the working key using the round counter as round number.
REQ-018 At the end of each EXPAND cycle, the block SHALL write the result to table entry counter+1, replace the working key with it, and increment the counter.
REQ-019 Round keys 1..10 SHALL be written at edges T+1..T+10; at edge T+10 the FSM SHALL return to IDLE.
REQ-020 rk_valid SHALL be high for exactly 11 consecutive cycles after edge T, with rk_idx 0..10 and rk_data equal to the entry written at the preceding edge.
REQ-021 busy SHALL be high exactly while the state is EXPAND.
REQ-022 done SHALL be high for exactly the one cycle after edge T+10.
REQ-023 keys_ready SHALL be set at edge T+10, cleared at edge T, and held otherwise.
REQ-024 start while in EXPAND SHALL be ignored, with no effect on the counter, table or outputs.
REQ-025 start high in the cycle done is high SHALL be accepted, since the state is IDLE, and restart expansion with the new key_in.
REQ-026 rd_key SHALL equal table[rd_idx] one edge after rd_idx is presented; rd_idx > 10 SHALL return all zeros.
REQ-027 Reads SHALL be allowed at any time; during EXPAND, an entry not yet rewritten returns its previous contents.
REQ-028 Table contents SHALL be retained in IDLE until the next accepted start.

Reset
REQ-029 On rst_n=0 at a clock edge, the block SHALL force state to IDLE, the counter to 0, and busy, done, keys_ready and rk_valid to 0.
REQ-030 On rst_n=0 at a clock edge, the block SHALL force rk_idx to 0, rk_data to 0 and rd_key to 0.
REQ-031 On rst_n=0 at a clock edge, the block SHALL clear all 11 key-table entries to 0.
REQ-032 Reset asserted mid-EXPAND SHALL abort the expansion, with no done pulse and keys_ready=0; start is ignored while rst_n=0.

Structure
REQ-033 NUM_ROUNDS, NUM_RKEYS (=11), KEY_W and the state enum type SHALL reside in the shared package aes_pkg.
REQ-034 The round transform SHALL be one instance of the existing combinational key_expansion block, driven by the counter (num_round) and the working key (input_key); no S-box or round-constant logic is duplicated here.

Verification
REQ-035 start with key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> rk_idx=1 data a0fafe17_88542cb1_23a33939_2a6c7605.
REQ-036 For the same key, rk_idx=10 SHALL produce d014f9a8_c9ee2589_e13f0cc8_b6630ca6, and done SHALL pulse exactly 11 cycles after the start cycle.
REQ-037 After REQ-036, read rd_idx=0,1,10,11 -> next-cycle rd_key = key_in, a0fafe17..., d014f9a8..., 0.
REQ-038 Assert start at the 4th busy cycle with a different key -> the stream and table are unchanged versus REQ-035/036.
REQ-039 Assert rst_n=0 one cycle at rk_idx=5 -> busy=0, keys_ready=0, no done; rd_idx=3 returns 0.
REQ-040 Back-to-back: start high in the done cycle with an all-zero key -> rk_idx=1 data 62636363_62636363_62636363_62636363, with keys_ready low during the run.
